// File: rtl/instruction_memory.sv
// Word-organised instruction store for the single-cycle MIPS datapath.
// Combinational fetch by byte PC, synchronous load port, resettable boot image.
module instruction_memory #(
  parameter int          DEPTH    = 256,
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc,
  output logic [31:0]     instruction,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic [31:0]     load_data,
  output logic            addr_err,
  output logic            misaligned
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [31:0] img(input int idx);
    logic [31:0] w;
    w = 32'h0000_0000;
    unique case (1'b1)
      (idx == 0): w = 32'h2008_0005;
      (idx == 1): w = 32'h2009_000A;
      (idx == 2): w = 32'h0109_5020;
      (idx == 3): w = 32'hAC0A_0000;
      default:    w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic [31:0]   words [DEPTH];
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          rd_ok;
  logic          wr_ok;
  logic          wr_en;
  logic          unused_load_lo;

  assign rd_idx = pc[AW+1:2];
  assign wr_idx = load_addr[AW+1:2];

  // Anything above the top stored word is out of range.
  assign rd_ok  = (pc >> (AW + 2)) == '0;
  assign wr_ok  = (load_addr >> (AW + 2)) == '0;
  assign wr_en  = load_en && wr_ok;

  assign unused_load_lo = ^load_addr[1:0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [31:0] word_q = img(g);
    logic [31:0] word_d;

    always_comb begin
      word_d = word_q;
      if (!rst_n) begin
        word_d = img(g);
      end else if (wr_en && (wr_idx == AW'(g))) begin
        word_d = load_data;
      end
    end

    always_ff @(posedge clk) begin
      word_q <= word_d;
    end

    assign words[g] = word_q;
  end

  assign instruction = rd_ok ? words[rd_idx] : NOP_WORD;
  assign addr_err    = !rd_ok;
  assign misaligned  = |pc[1:0];

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: expectations queued on drive,
// popped and checked with immediate assertions after the fetch settles.
module tb_instruction_memory;

  localparam int DEPTH = 256;
  localparam int PC_W  = 32;

  logic            clk;
  logic            rst_n;
  logic [PC_W-1:0] pc;
  logic [31:0]     instruction;
  logic            load_en;
  logic [PC_W-1:0] load_addr;
  logic [31:0]     load_data;
  logic            addr_err;
  logic            misaligned;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   failed;

  instruction_memory #(
    .DEPTH(DEPTH),
    .PC_W(PC_W),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc(pc),
    .instruction(instruction),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .addr_err(addr_err),
    .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL timeout");
    $fatal(1);
  end

  task automatic push(input string tag, input logic [31:0] i,
                      input logic e, input logic m);
    exp_t x;
    x.tag   = tag;
    x.instr = i;
    x.err   = e;
    x.mis   = m;
    sb.push_back(x);
  endtask

  task automatic compare();
    exp_t x;
    tests++;
    assert (sb.size() != 0) else begin
      failed++;
      $error("FAIL sb_empty got 0 entries exp 1");
    end
    if (sb.size() == 0) return;
    x = sb.pop_front();
    tests++;
    assert (instruction === x.instr) else begin
      failed++;
      $error("FAIL %s instr got %h exp %h", x.tag, instruction, x.instr);
    end
    tests++;
    assert (addr_err === x.err) else begin
      failed++;
      $error("FAIL %s addr_err got %b exp %b", x.tag, addr_err, x.err);
    end
    tests++;
    assert (misaligned === x.mis) else begin
      failed++;
      $error("FAIL %s misaligned got %b exp %b", x.tag, misaligned, x.mis);
    end
  endtask

  task automatic fetch(input string tag, input logic [PC_W-1:0] a,
                       input logic [31:0] i, input logic e, input logic m);
    @(negedge clk);
    pc = a;
    push(tag, i, e, m);
    #1;
    compare();
  endtask

  task automatic edge_done();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst_n     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    pc        = '0;

    // power-up image, no reset applied
    push("pwr_w0", 32'h2008_0005, 1'b0, 1'b0);
    #1;
    compare();
    #4;
    pc = 32'd4;
    push("pwr_w1", 32'h2009_000A, 1'b0, 1'b0);
    #1;
    compare();
    #4;
    pc = 32'd8;
    push("pwr_w2", 32'h0109_5020, 1'b0, 1'b0);
    #1;
    compare();

    fetch("w3", 32'd12, 32'hAC0A_0000, 1'b0, 1'b0);
    fetch("w4", 32'd16, 32'h0000_0000, 1'b0, 1'b0);
    fetch("last", 32'd1020, 32'h0000_0000, 1'b0, 1'b0);
    fetch("oob", 32'd1024, 32'h0000_0000, 1'b1, 1'b0);
    fetch("oob_hi", 32'hFFFF_FFF0, 32'h0000_0000, 1'b1, 1'b0);
    fetch("mis6", 32'd6, 32'h2009_000A, 1'b0, 1'b1);
    fetch("mis1", 32'd1, 32'h2008_0005, 1'b0, 1'b1);
    fetch("oob_mis", 32'd1027, 32'h0000_0000, 1'b1, 1'b1);

    // read-during-write: old word before the edge, new word after
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 32'd8;
    load_data = 32'hDEAD_BEEF;
    pc        = 32'd8;
    push("rdw_old", 32'h0109_5020, 1'b0, 1'b0);
    #1;
    compare();
    push("rdw_new", 32'hDEAD_BEEF, 1'b0, 1'b0);
    edge_done();
    compare();
    load_en = 1'b0;

    // reset restores the image
    @(negedge clk);
    rst_n = 1'b0;
    edge_done();
    rst_n = 1'b1;
    fetch("rst_w2", 32'd8, 32'h0109_5020, 1'b0, 1'b0);

    // reset wins over a same-cycle load
    @(negedge clk);
    rst_n     = 1'b0;
    load_en   = 1'b1;
    load_addr = 32'd0;
    load_data = 32'h1234_5678;
    edge_done();
    rst_n   = 1'b1;
    load_en = 1'b0;
    fetch("rst_prio", 32'd0, 32'h2008_0005, 1'b0, 1'b0);

    // out-of-range load must not alias onto a stored word
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 32'd2000;
    load_data = 32'hFFFF_FFFF;
    edge_done();
    load_en = 1'b0;
    fetch("oobw_w0", 32'd0, 32'h2008_0005, 1'b0, 1'b0);
    fetch("oobw_w1", 32'd4, 32'h2009_000A, 1'b0, 1'b0);
    fetch("oobw_w2", 32'd8, 32'h0109_5020, 1'b0, 1'b0);
    fetch("oobw_w3", 32'd12, 32'hAC0A_0000, 1'b0, 1'b0);
    fetch("oobw_alias", 32'd976, 32'h0000_0000, 1'b0, 1'b0);

    // load low address bits are ignored
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 32'd14;
    load_data = 32'hCAFE_0003;
    edge_done();
    load_en = 1'b0;
    fetch("ld_mis", 32'd12, 32'hCAFE_0003, 1'b0, 1'b0);
    fetch("ld_mis_nb", 32'd8, 32'h0109_5020, 1'b0, 1'b0);

    // top word is writable and readable
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 32'd1020;
    load_data = 32'h0BAD_F00D;
    edge_done();
    load_en = 1'b0;
    fetch("ld_top", 32'd1020, 32'h0BAD_F00D, 1'b0, 1'b0);
    fetch("ld_top_w0", 32'd0, 32'h2008_0005, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
